jt10_adpcma_rom_if: RTL and testbench
=====================================

JT10_ADPCMA_ROM_IF -- requirements
Module: jt10_adpcma_rom_if

Interface
REQ-001 SHALL have parameter CACHE_EN, default 1, meaning: 1 enables the single-entry last-byte cache; 0 sends every read to memory.
REQ-002 SHALL have port clk  input  1  system clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port addr  input  20  ADPCM-A byte address from the channel driver.
REQ-005 SHALL have port bank  input  4  ADPCM-A bank from the channel driver.
REQ-006 SHALL have port roe_n  input  1  ROM output enable from the driver; active low.
REQ-007 SHALL have port datain  output  8  ROM byte returned to the driver.
REQ-008 SHALL have port rom_addr  output  24  external memory byte address, {bank,addr}.
REQ-009 SHALL have port rom_req  output  1  level request to external memory.
REQ-010 SHALL have port rom_ack  input  1  one-cycle acknowledge; rom_data is valid in the same cycle.
REQ-011 SHALL have port rom_data  input  8  external memory read data.
REQ-012 SHALL have port late  output  1  sticky flag: a new read arrived before the previous one completed.
REQ-013 SHALL have port late_clr  input  1  synchronous clear for late.

Function
REQ-014 SHALL register roe_n every clk cycle (roe_l); fetch trigger = roe_l & ~roe_n (falling edge).
REQ-015 SHALL, on a trigger, capture key = {bank,addr} into pending register.
REQ-016 SHALL implement FSM IDLE, REQ, HOLD.
REQ-017 IDLE: on trigger, if CACHE_EN=1 and cache valid and key equals cached key, update datain with the cached byte on the next cycle and stay in IDLE (hit); otherwise go to REQ.
REQ-018 REQ: drive rom_req=1 and rom_addr=pending key; rom_addr SHALL stay stable while rom_req=1.
REQ-019 REQ: when rom_ack=1, latch rom_data into datain and into the cache, mark the cache valid with the key, drop rom_req in the next cycle, and go to HOLD.
REQ-020 HOLD: one cycle with rom_req=0, then go to IDLE, or go directly to REQ if a queued request exists.
REQ-021 SHALL queue at most one request: a trigger while in REQ or HOLD overwrites the queue key, sets queued, and sets late=1.
REQ-022 The queued request SHALL be served in the HOLD-to-IDLE transition, with a cache check identical to REQ-017.
REQ-023 Trigger and rom_ack in the same cycle SHALL complete the current read and queue the new one; no data SHALL be lost.
REQ-024 Trigger and late_clr in the same cycle SHALL leave late=1 (set wins).
REQ-025 datain SHALL change only on an ack latch or a cache hit; it SHALL otherwise hold its last value.
REQ-026 rom_ack while in IDLE or HOLD SHALL be ignored.
REQ-027 rom_addr SHALL be 24 bits, zero-extended; no arithmetic SHALL be applied to it.

Reset
REQ-028 While rst_n=0, the block SHALL hold: state=IDLE, rom_req=0, rom_addr=0, datain=0, late=0, cache valid=0, queued=0, roe_l=1.
REQ-029 Reset asserted mid-request SHALL drop rom_req immediately; an ack arriving after release SHALL be ignored per REQ-026.
REQ-030 The first trigger after reset SHALL always miss.

Verification
REQ-031 Scenario: bank=2, addr=0x00345, roe_n falls; memory acks 3 cycles after the request with 0xA5 -> rom_req=1 with rom_addr=0x200345 until the ack; datain=0xA5 on the cycle after the ack.
REQ-032 Scenario: the same address is retriggered with CACHE_EN=1 -> rom_req stays 0; datain=0xA5 one cycle after the trigger. With CACHE_EN=0 -> a new request is issued.
REQ-033 Scenario: a second trigger (addr 0x00346) during an outstanding request -> late=1; the second request is issued after HOLD; datain takes each ack's value in order.
REQ-034 Scenario: trigger coincides with rom_ack -> the first data is latched and the queued request follows; late=1.
REQ-035 Scenario: rst_n pulsed low while rom_req=1, then ack asserted -> all outputs are 0 and the ack is ignored; the next trigger misses.
REQ-036 Scenario: late=1, then late_clr=1 with no trigger -> late=0 next cycle. late_clr coinciding with a trigger during REQ -> late remains 1.

Source files
------------

// File: rtl/jt10_adpcma_rom_if.sv
// ADPCM-A ROM interface: turns the channel driver's roe_n strobes into level
// requests on an external byte memory, with a one-deep request queue and an
// optional single-entry last-byte cache.
module jt10_adpcma_rom_if #(
    parameter int CACHE_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] addr,
    input  logic [3:0]  bank,
    input  logic        roe_n,
    output logic [7:0]  datain,
    output logic [23:0] rom_addr,
    output logic        rom_req,
    input  logic        rom_ack,
    input  logic [7:0]  rom_data,
    output logic        late,
    input  logic        late_clr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_HOLD
    } state_t;

    state_t      r_state;
    logic        r_roe_l;
    logic [23:0] r_pend_key;
    logic [23:0] r_q_key;
    logic        r_queued;
    logic        r_late;
    logic [7:0]  r_datain;
    logic [23:0] r_cache_key;
    logic [7:0]  r_cache_data;
    logic        r_cache_vld;

    state_t      w_state_nxt;
    logic [23:0] w_pend_nxt;
    logic [23:0] w_q_key_nxt;
    logic        w_queued_nxt;
    logic        w_late_nxt;
    logic [7:0]  w_datain_nxt;
    logic [23:0] w_cache_key_nxt;
    logic [7:0]  w_cache_data_nxt;
    logic        w_cache_vld_nxt;

    logic [23:0] w_key;
    logic        w_trig;
    logic        w_hit_key;
    logic        w_hit_q;
    logic        w_late_set;
    logic        w_serve;
    logic [23:0] w_serve_key;
    logic        w_serve_hit;

    assign w_key  = {bank, addr};
    assign w_trig = r_roe_l & ~roe_n;

    assign w_hit_key  = (CACHE_EN != 0) && r_cache_vld && (w_key == r_cache_key);
    assign w_hit_q    = (CACHE_EN != 0) && r_cache_vld && (r_q_key == r_cache_key);
    // A strobe is late whenever an earlier read is still in flight or waiting.
    assign w_late_set = w_trig && ((r_state != ST_IDLE) || r_queued);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        w_state_nxt      = r_state;
        w_pend_nxt       = r_pend_key;
        w_q_key_nxt      = r_q_key;
        w_queued_nxt     = r_queued;
        w_late_nxt       = late_clr ? 1'b0 : r_late;
        w_datain_nxt     = r_datain;
        w_cache_key_nxt  = r_cache_key;
        w_cache_data_nxt = r_cache_data;
        w_cache_vld_nxt  = r_cache_vld;
        w_serve          = 1'b0;
        w_serve_key      = w_key;
        w_serve_hit      = w_hit_key;

        case (r_state)
            ST_REQ: begin
                if (rom_ack) begin
                    w_datain_nxt     = rom_data;
                    w_cache_data_nxt = rom_data;
                    w_cache_key_nxt  = r_pend_key;
                    w_cache_vld_nxt  = 1'b1;
                    w_state_nxt      = ST_HOLD;
                end
                if (w_trig) begin
                    w_q_key_nxt  = w_key;
                    w_queued_nxt = 1'b1;
                end
            end
            ST_IDLE, ST_HOLD: begin
                w_state_nxt = ST_IDLE;
                // The queued read is older than a strobe arriving now, so it goes first.
                if (r_queued) begin
                    w_serve      = 1'b1;
                    w_serve_key  = r_q_key;
                    w_serve_hit  = w_hit_q;
                    w_queued_nxt = w_trig;
                    if (w_trig) begin
                        w_q_key_nxt = w_key;
                    end
                end else if (w_trig) begin
                    w_serve = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_serve) begin
            if (w_serve_hit) begin
                w_datain_nxt = r_cache_data;
            end else begin
                w_pend_nxt  = w_serve_key;
                w_state_nxt = ST_REQ;
            end
        end

        if (w_late_set) begin
            w_late_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_roe_l     <= 1'b1;
            r_pend_key  <= '0;
            r_queued    <= 1'b0;
            r_late      <= 1'b0;
            r_datain    <= '0;
            r_cache_vld <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state     <= w_state_nxt;
            r_roe_l     <= roe_n;
            r_pend_key  <= w_pend_nxt;
            r_queued    <= w_queued_nxt;
            r_late      <= w_late_nxt;
            r_datain    <= w_datain_nxt;
            r_cache_vld <= w_cache_vld_nxt;
        end
    end

    // NOTE: payload registers are not reset; r_cache_vld and r_queued gate every use of them.
    always_ff @(posedge clk) begin
        r_q_key      <= w_q_key_nxt;
        r_cache_key  <= w_cache_key_nxt;
        r_cache_data <= w_cache_data_nxt;
    end

    assign rom_req  = (r_state == ST_REQ);
    assign rom_addr = r_pend_key;
    assign datain   = r_datain;
    assign late     = r_late;

endmodule

// File: tb/tb_jt10_adpcma_rom_if.sv
// Directed bench for jt10_adpcma_rom_if: a scoreboard of expected request
// addresses/bytes is filled on each strobe and drained as the memory acks.
module tb_jt10_adpcma_rom_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] addr;
    logic [3:0]  bank;
    logic        roe_n;
    logic [7:0]  datain;
    logic [23:0] rom_addr;
    logic        rom_req;
    logic        rom_ack;
    logic [7:0]  rom_data;
    logic        late;
    logic        late_clr;

    // Second instance without cache, served by an automatic memory responder.
    logic [7:0]  nc_datain;
    logic [23:0] nc_addr;
    logic        nc_req;
    logic        nc_ack;
    logic [7:0]  nc_data;
    logic        nc_late;
    logic        nc_req_d;
    int          nc_reqs;

    int n_checks = 0;
    int n_errors = 0;

    logic [23:0] exp_addr[$];
    logic [7:0]  exp_data[$];

    always #5 clk = ~clk;

    jt10_adpcma_rom_if #(.CACHE_EN(1)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .bank     (bank),
        .roe_n    (roe_n),
        .datain   (datain),
        .rom_addr (rom_addr),
        .rom_req  (rom_req),
        .rom_ack  (rom_ack),
        .rom_data (rom_data),
        .late     (late),
        .late_clr (late_clr)
    );

    jt10_adpcma_rom_if #(.CACHE_EN(0)) u_nc (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .bank     (bank),
        .roe_n    (roe_n),
        .datain   (nc_datain),
        .rom_addr (nc_addr),
        .rom_req  (nc_req),
        .rom_ack  (nc_ack),
        .rom_data (nc_data),
        .late     (nc_late),
        .late_clr (late_clr)
    );

    function automatic logic [7:0] mem(input logic [23:0] a);
        return a[7:0] ^ 8'hE0;
    endfunction

    assign nc_data = mem(nc_addr);

    initial begin
        nc_ack   = 1'b0;
        nc_req_d = 1'b0;
        nc_reqs  = 0;
    end

    always @(posedge clk) begin
        nc_ack   <= nc_req & ~nc_ack;
        nc_req_d <= nc_req;
        if (nc_req && !nc_req_d) nc_reqs <= nc_reqs + 1;
    end

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle low pulse on roe_n; a predicted miss is pushed to the scoreboard.
    task automatic do_trig(input logic [3:0] b, input logic [19:0] a, input bit miss);
        bank  = b;
        addr  = a;
        roe_n = 1'b0;
        if (miss) begin
            exp_addr.push_back({b, a});
            exp_data.push_back(mem({b, a}));
        end
        tick();
        roe_n = 1'b1;
    endtask

    task automatic pop_addr(input string tag);
        check({tag, "_sb_addr"}, 24'(exp_addr.size() != 0), 24'd1);
        if (exp_addr.size() != 0) check({tag, "_rom_addr"}, rom_addr, exp_addr.pop_front());
    endtask

    task automatic pop_data(input string tag);
        check({tag, "_sb_data"}, 24'(exp_data.size() != 0), 24'd1);
        if (exp_data.size() != 0) check({tag, "_datain"}, 24'(datain), 24'(exp_data.pop_front()));
    endtask

    // Memory acknowledges the outstanding request with its own byte.
    task automatic do_ack(input string tag);
        check({tag, "_req_hi"}, 24'(rom_req), 24'd1);
        pop_addr(tag);
        rom_ack  = 1'b1;
        rom_data = mem(rom_addr);
        tick();
        rom_ack  = 1'b0;
        pop_data(tag);
        check({tag, "_req_lo"}, 24'(rom_req), 24'd0);
    endtask

    initial begin
        int n0;
        rst_n    = 1'b0;
        roe_n    = 1'b1;
        addr     = '0;
        bank     = '0;
        rom_ack  = 1'b0;
        rom_data = '0;
        late_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",    24'(rom_req), 24'd0);
        check("rst_addr",   rom_addr,     24'd0);
        check("rst_datain", 24'(datain),  24'd0);
        check("rst_late",   24'(late),    24'd0);
        rst_n = 1'b1;
        tick();

        // First fetch: request held stable until the ack three cycles later.
        do_trig(4'd2, 20'h00345, 1'b1);
        check("s31_req",  24'(rom_req), 24'd1);
        check("s31_addr", rom_addr,     24'h200345);
        tick();
        tick();
        check("s31_hold_req",  24'(rom_req), 24'd1);
        check("s31_hold_addr", rom_addr,     24'h200345);
        check("s31_no_data",   24'(datain),  24'd0);
        do_ack("s31");
        tick();

        // Same address again: cached instance stays quiet, uncached one fetches.
        n0 = nc_reqs;
        do_trig(4'd2, 20'h00345, 1'b0);
        check("s32_hit_req",  24'(rom_req), 24'd0);
        check("s32_hit_data", 24'(datain),  24'h0000A5);
        tick();
        tick();
        check("s32_hit_req2", 24'(rom_req), 24'd0);
        check("s32_nc_reqs",  24'(nc_reqs), 24'(n0 + 1));

        // Second strobe during an outstanding request is queued and flagged late.
        do_trig(4'd2, 20'h00347, 1'b1);
        tick();
        check("s33_late0", 24'(late), 24'd0);
        do_trig(4'd2, 20'h00346, 1'b1);
        check("s33_late1",  24'(late), 24'd1);
        check("s33_stable", rom_addr,  24'h200347);
        do_ack("s33a");
        tick();
        do_ack("s33b");
        tick();

        late_clr = 1'b1;
        tick();
        late_clr = 1'b0;
        check("s36_clr", 24'(late), 24'd0);

        // Strobe in the same cycle as the ack.
        do_trig(4'd2, 20'h00348, 1'b1);
        tick();
        pop_addr("s34a");
        addr     = 20'h00349;
        roe_n    = 1'b0;
        exp_addr.push_back(24'h200349);
        exp_data.push_back(mem(24'h200349));
        rom_ack  = 1'b1;
        rom_data = mem(rom_addr);
        tick();
        roe_n    = 1'b1;
        rom_ack  = 1'b0;
        pop_data("s34a");
        check("s34_late",   24'(late),    24'd1);
        check("s34_req_lo", 24'(rom_req), 24'd0);
        tick();
        do_ack("s34b");
        tick();

        // late_clr loses to a simultaneous strobe; the queued repeat then hits.
        late_clr = 1'b1;
        tick();
        late_clr = 1'b0;
        check("s36_clr2", 24'(late), 24'd0);
        do_trig(4'd2, 20'h0034A, 1'b1);
        tick();
        roe_n    = 1'b0;
        late_clr = 1'b1;
        tick();
        roe_n    = 1'b1;
        late_clr = 1'b0;
        check("s36_set_wins", 24'(late), 24'd1);
        do_ack("s36");
        tick();
        check("s36_qhit_req", 24'(rom_req), 24'd0);
        tick();
        check("s36_qhit_req2", 24'(rom_req), 24'd0);

        // Reset in the middle of a request; a stray ack afterwards is ignored.
        do_trig(4'd2, 20'h00350, 1'b1);
        check("s35_req", 24'(rom_req), 24'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("s35_rst_req",    24'(rom_req), 24'd0);
        check("s35_rst_addr",   rom_addr,     24'd0);
        check("s35_rst_datain", 24'(datain),  24'd0);
        check("s35_rst_late",   24'(late),    24'd0);
        exp_addr.delete();
        exp_data.delete();
        tick();
        rst_n    = 1'b1;
        rom_ack  = 1'b1;
        rom_data = 8'h55;
        tick();
        rom_ack  = 1'b0;
        check("s35_ign_datain", 24'(datain),  24'd0);
        check("s35_ign_req",    24'(rom_req), 24'd0);
        tick();
        do_trig(4'd2, 20'h00345, 1'b1);
        check("s35_miss", 24'(rom_req), 24'd1);
        do_ack("s35");
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
